// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter
//  Description : Single-port board SRAM arbiter shared by the IF stage
//                (read-only) and the MEM stage (load/store). Sequences the
//                multi-cycle SRAM read/write strobes, returns a one-cycle ack
//                with registered read data, and raises pipeline stall
//                requests. MEM has priority, bounded by an IF starvation
//                counter.
//  Revision    : 1.0  initial release
// ============================================================================
module sram_arbiter #(
    parameter int WAIT_CYCLES  = 1,   // 1..7
    parameter int STARVE_LIMIT = 4    // 1..15
) (
    input  logic        clk,
    input  logic        rst,
    // IF stage port
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_ack,
    // MEM stage port
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_ack,
    // Stall requests to the pipeline controller
    output logic        if_stall_req,
    output logic        mem_stall_req,
    // SRAM interface
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic        ram_data_oe,
    output logic        ram_ce_n,
    output logic        ram_oe_n,
    output logic        ram_we_n
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD       = 3'd1,
        S_WR_SETUP = 3'd2,
        S_WR_PULSE = 3'd3,
        S_WR_HOLD  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    // Last value of the wait counter in RD (WAIT_CYCLES+1 cycles) and in
    // WR_PULSE (WAIT_CYCLES cycles); both counts start at 0.
    localparam logic [2:0] c_rd_last     = 3'(WAIT_CYCLES);
    localparam logic [2:0] c_pulse_last  = 3'(WAIT_CYCLES - 1);
    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    state_t      r_state;
    logic [2:0]  r_wait;
    logic [3:0]  r_starve;
    logic        r_grant_mem;
    logic        r_if_ack;
    logic        r_mem_ack;
    logic [15:0] r_if_rdata;
    logic [15:0] r_mem_rdata;
    logic [15:0] r_ram_addr;
    logic [15:0] r_ram_wdata;
    logic        r_data_oe;
    logic        r_ce_n;
    logic        r_oe_n;
    logic        r_we_n;

    // MEM wins unless IF is pending and has been passed over STARVE_LIMIT times.
    logic w_mem_wins;
    assign w_mem_wins = mem_req && ((r_starve < c_starve_limit) || !if_req);

    // Arbitration and SRAM timing sequencer; every strobe is set on the edge
    // that enters the state it belongs to, so all outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wait      <= 3'd0;
            r_starve    <= 4'd0;
            r_grant_mem <= 1'b0;
            r_if_ack    <= 1'b0;
            r_mem_ack   <= 1'b0;
            r_if_rdata  <= 16'd0;
            r_mem_rdata <= 16'd0;
            r_ram_addr  <= 16'd0;
            r_ram_wdata <= 16'd0;
            r_data_oe   <= 1'b0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
        end else begin
            r_if_ack  <= 1'b0;
            r_mem_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_wait <= 3'd0;
                    if (w_mem_wins) begin
                        r_grant_mem <= 1'b1;
                        r_ram_addr  <= mem_addr;
                        r_ram_wdata <= mem_wdata;
                        r_ce_n      <= 1'b0;
                        if (if_req) begin
                            if (r_starve < c_starve_limit) begin
                                r_starve <= r_starve + 4'd1;
                            end
                        end else begin
                            r_starve <= 4'd0;
                        end
                        if (mem_we) begin
                            r_data_oe <= 1'b1;
                            r_state   <= S_WR_SETUP;
                        end else begin
                            r_oe_n  <= 1'b0;
                            r_state <= S_RD;
                        end
                    end else if (if_req) begin
                        r_grant_mem <= 1'b0;
                        r_ram_addr  <= if_addr;
                        r_starve    <= 4'd0;
                        r_ce_n      <= 1'b0;
                        r_oe_n      <= 1'b0;
                        r_state     <= S_RD;
                    end else begin
                        r_starve <= 4'd0;
                    end
                end
                S_RD: begin
                    if (r_wait == c_rd_last) begin
                        // Last RD edge: capture into the granted port only.
                        if (r_grant_mem) begin
                            r_mem_rdata <= ram_rdata;
                            r_mem_ack   <= 1'b1;
                        end else begin
                            r_if_rdata <= ram_rdata;
                            r_if_ack   <= 1'b1;
                        end
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_wait <= r_wait + 3'd1;
                    end
                end
                S_WR_SETUP: begin
                    r_we_n  <= 1'b0;
                    r_wait  <= 3'd0;
                    r_state <= S_WR_PULSE;
                end
                S_WR_PULSE: begin
                    if (r_wait == c_pulse_last) begin
                        r_we_n  <= 1'b1;
                        r_state <= S_WR_HOLD;
                    end else begin
                        r_wait <= r_wait + 3'd1;
                    end
                end
                S_WR_HOLD: begin
                    r_ce_n    <= 1'b1;
                    r_data_oe <= 1'b0;
                    r_mem_ack <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ce_n    <= 1'b1;
                    r_oe_n    <= 1'b1;
                    r_we_n    <= 1'b1;
                    r_data_oe <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign if_rdata      = r_if_rdata;
    assign if_ack        = r_if_ack;
    assign mem_rdata     = r_mem_rdata;
    assign mem_ack       = r_mem_ack;
    assign ram_addr      = r_ram_addr;
    assign ram_wdata     = r_ram_wdata;
    assign ram_data_oe   = r_data_oe;
    assign ram_ce_n      = r_ce_n;
    assign ram_oe_n      = r_oe_n;
    assign ram_we_n      = r_we_n;
    assign if_stall_req  = if_req & ~r_if_ack;
    assign mem_stall_req = mem_req & ~r_mem_ack;

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Arbitrates the single-port board SRAM between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Sequences multi-cycle SRAM read and write timing.
- Returns a one-cycle ack and registered read data to the served port, and drives the stall requests consumed by the pipeline stall controller.
- MEM has priority over IF, bounded by an IF anti-starvation counter.

Parameters:
- WAIT_CYCLES, 1, SRAM access wait states: read OE-low length is WAIT_CYCLES+1 and write WE-low pulse length is WAIT_CYCLES; legal range 1..7.
- STARVE_LIMIT, 4, number of consecutive MEM grants with IF pending after which IF is forced; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- if_req  in  1  IF read request; level, held until if_ack
- if_addr  in  16  IF word address; stable while if_req
- if_rdata  out  16  IF read data; valid in the if_ack cycle, held until the next IF ack
- if_ack  out  1  one-cycle completion pulse for IF
- mem_req  in  1  MEM request; level, held until mem_ack
- mem_we  in  1  1 = write, 0 = read; stable while mem_req
- mem_addr  in  16  MEM word address
- mem_wdata  in  16  MEM write data
- mem_rdata  out  16  MEM read data; valid in the mem_ack cycle, held until the next MEM ack
- mem_ack  out  1  one-cycle completion pulse for MEM
- if_stall_req  out  1  if_req & ~if_ack
- mem_stall_req  out  1  mem_req & ~mem_ack
- ram_addr  out  16  SRAM address (registered)
- ram_wdata  out  16  SRAM write data (registered)
- ram_rdata  in  16  SRAM read data
- ram_data_oe  out  1  1 = drive the bidirectional data bus (top-level tristate)
- ram_ce_n  out  1  chip enable, active-low
- ram_oe_n  out  1  output enable, active-low
- ram_we_n  out  1  write enable, active-low

Behaviour:
- Reset is rst, synchronous, active-high. State goes to IDLE. All of the following are 0: if_ack, mem_ack, if_rdata, mem_rdata, ram_addr, ram_wdata, ram_data_oe, wait counter, starve counter. ram_ce_n, ram_oe_n and ram_we_n are 1.
- Reset mid-transaction aborts the transaction: no ack is issued and the write pulse ends at that edge. The requester re-issues after reset.
- All SRAM control, ack and rdata outputs are registered. There is no combinational path from any req input to a ram_* output.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE, with grant and address/data captured at the clock edge:
  - mem_req and (starve < STARVE_LIMIT or ~if_req): grant MEM. Go to RD if ~mem_we, else WR_SETUP.
  - else if_req: grant IF, go to RD.
  - else stay in IDLE.
- RD: ce_n=0, oe_n=0, data_oe=0. Lasts WAIT_CYCLES+1 cycles. ram_rdata is sampled on the last RD edge into the granted port's rdata register. Then go to DONE.
- WR_SETUP: 1 cycle. ce_n=0, data_oe=1, we_n=1.
- WR_PULSE: WAIT_CYCLES cycles. we_n=0, data_oe=1.
- WR_HOLD: 1 cycle. we_n=1, data_oe=1, address and data held. Then go to DONE.
- DONE: 1 cycle. Granted port's ack=1, all strobes inactive. Next state is IDLE unconditionally, so there are no back-to-back grants without an IDLE cycle.
- Latency, with the request seen in IDLE cycle t:
  - read ack at t+2+WAIT_CYCLES (t+3 at default);
  - write ack at t+3+WAIT_CYCLES (t+4 at default).
- Requester contract: deassert req or present a new request in the cycle after ack. The arbiter ignores requests except in IDLE.
- Anti-starvation counter:
  - +1 on each MEM grant while if_req=1;
  - cleared on each IF grant, and cleared when if_req=0 in IDLE;
  - saturates at STARVE_LIMIT.
- Simultaneous requests: MEM wins unless the counter equals STARVE_LIMIT, in which case IF wins.
- Inputs are not sampled after the grant. Address or data changes mid-transaction have no effect.
- rdata of the non-granted port is unchanged.

Test Plan:
- Single IF read, WAIT_CYCLES=1: if_addr=0x0040, SRAM model returns 0x1234 -> oe_n low for 2 cycles, if_ack pulse exactly at t+3, if_rdata=0x1234, if_stall_req high t..t+2.
- MEM write: mem_we=1, addr=0xBF00, data=0xA5A5 -> WR_SETUP 1 cycle, we_n low exactly 1 cycle, data_oe high 3 cycles, mem_ack at t+4, SRAM model holds 0xA5A5 at 0xBF00.
- Simultaneous if_req and mem_req (read 0x0010) -> MEM served first (mem_ack at t+3), then IF granted in the next IDLE; if_rdata unchanged during the MEM transaction.
- Starvation: mem_req held continuously with a new address after each ack, if_req high, STARVE_LIMIT=4 -> exactly 4 MEM acks, then one IF ack, then the counter restarts at 0.
- Reset asserted during WR_PULSE -> next cycle we_n=1, ce_n=1, data_oe=0, no mem_ack; state returns to IDLE and the re-issued write completes normally.
- WAIT_CYCLES=3 read -> oe_n low 4 cycles, ack at t+5.
